rv32i_idex_stage: RTL and testbench
===================================

// Module: rv32i_idex_stage
// PURPOSE
//  ID/EX pipeline register plus operand forwarding/select feeding the execute ALU.
//  Captures decoded fields each cycle and resolves RAW hazards against EX/MEM and MEM/WB.
//  Produces final alu_data1/2 + alu opcode; detects load-use hazards and requests a one-cycle stall.
// PARAMETERS
//  WORD_WTH      32  datapath / register width
//  ADDR_WTH      32  PC width
//  REG_INX_WTH    5  register index width
//  ALU_OP_WTH     5  ALU opcode width (ADD=5'b00000)
//  WB_MUX_WTH     2  write-back select width
//  FORW_MUX_WTH   2  forwarding select width
// PORTS
//  clk_i            in   1             clock, rising edge
//  rst_n_i          in   1             asynchronous, active-low reset
//  id_valid_i       in   1             decode slot holds an instruction
//  id_pc_i          in   ADDR_WTH      instruction PC
//  id_rs1_data_i    in   WORD_WTH      regfile read data rs1
//  id_rs2_data_i    in   WORD_WTH      regfile read data rs2
//  id_imm_i         in   WORD_WTH      sign-extended immediate
//  id_rs1_idx_i     in   REG_INX_WTH   source index 1
//  id_rs2_idx_i     in   REG_INX_WTH   source index 2
//  id_rd_idx_i      in   REG_INX_WTH   destination index
//  id_rd_we_i       in   1             destination write enable
//  id_is_load_i     in   1             instruction is a load
//  id_op1_pc_i      in   1             1: operand1 = PC, 0: rs1
//  id_op2_imm_i     in   1             1: operand2 = imm, 0: rs2
//  id_alu_op_i      in   ALU_OP_WTH    ALU opcode
//  id_wb_sel_i      in   WB_MUX_WTH    write-back source select
//  flush_i          in   1             kill ID/EX contents (branch redirect)
//  exmem_rd_idx_i   in   REG_INX_WTH   EX/MEM destination
//  exmem_rd_we_i    in   1             EX/MEM write enable
//  exmem_res_i      in   WORD_WTH      EX/MEM ALU result
//  memwb_rd_idx_i   in   REG_INX_WTH   MEM/WB destination
//  memwb_rd_we_i    in   1             MEM/WB write enable
//  memwb_res_i      in   WORD_WTH      MEM/WB write-back data
//  id_stall_o       out  1             hold PC and IF/ID (load-use)
//  ex_valid_o       out  1             EX slot valid
//  alu_data1_o      out  WORD_WTH      ALU operand 1
//  alu_data2_o      out  WORD_WTH      ALU operand 2
//  alu_opcode_o     out  ALU_OP_WTH    ALU opcode
//  ex_store_data_o  out  WORD_WTH      forwarded rs2 (store data)
//  ex_pc_o          out  ADDR_WTH      EX PC
//  ex_imm_o         out  WORD_WTH      EX immediate
//  ex_rd_idx_o / ex_rd_we_o / ex_is_load_o / ex_wb_sel_o  out  -  registered controls
// BEHAVIOUR
//  Reset: all registers 0; ex_valid_o=0, ex_rd_we_o=0, alu_opcode_o=ADD, id_stall_o=0.
//  Register update each edge, priority: flush_i > load-use bubble > capture.
//   flush_i: ex_valid, ex_rd_we, ex_is_load <= 0 (bubble); datapath regs don't-care.
//   load-use: ex_is_load & ex_valid & ex_rd_we & ex_rd!=0 & id_valid_i & (rd==id_rs1 | rd==id_rs2)
//    -> id_stall_o=1 (combinational, same cycle); EX gets bubble next edge.
//   otherwise capture all id_* fields; ex_valid <= id_valid_i; rd_we gated by id_valid_i.
//  flush_i forces id_stall_o=0.
//  Forwarding (combinational on registered rs idx), per source:
//   idx==0 -> regfile value (never forward x0);
//   exmem_rd_we_i & exmem_rd_idx_i==idx -> exmem_res_i (highest priority);
//   else memwb_rd_we_i & memwb_rd_idx_i==idx -> memwb_res_i; else registered regfile data.
//   Encoding FORW_MUX_WTH: 00 reg, 01 EX/MEM, 10 MEM/WB.
//  Operand select after forwarding: data1 = op1_pc ? pc : fwd_rs1; data2 = op2_imm ? imm : fwd_rs2.
//  ex_store_data_o = fwd_rs2 always. Latency ID->ALU operands: 1 cycle.
//  Reset asserted mid-stream: immediate clear, no partial state retained.
// STRUCTURE
//  Shared package: ALU opcode localparams, FORW select codes, WB select codes.
//  One sub-module: rv32i_fwd_mux (idx + EX/MEM + MEM/WB -> select + data), instanced twice.
// TESTING
//  Reset: rst_n_i=0 mid-run -> ex_valid_o=0, ex_rd_we_o=0, alu_opcode_o=0 immediately.
//  EX/MEM fwd: EX/MEM rd=5 res=0x1234, ID rs1=5 -> alu_data1_o=0x1234.
//  Priority: EX/MEM and MEM/WB both rd=7 (0xAA / 0xBB) -> operand=0xAA; rd=0 both -> regfile value.
//  Load-use: lw x3 in EX, add uses x3 -> id_stall_o=1 one cycle, EX bubble, then forward from MEM/WB.
//  Flush during load-use: flush_i=1 -> id_stall_o=0, ex_valid_o=0 next cycle.
//  Select: op1_pc=1 pc=0x100, op2_imm=1 imm=-4 -> data1=0x100, data2=0xFFFFFFFC, store data = fwd rs2.

Source files
------------

// File: rtl/rv32i_idex_pkg.sv
// rv32i_idex_pkg: shared widths, ALU/forwarding/write-back select codes for the ID/EX stage.
package rv32i_idex_pkg;

    localparam int WORD_WTH     = 32;
    localparam int ADDR_WTH     = 32;
    localparam int REG_INX_WTH  = 5;
    localparam int ALU_OP_WTH   = 5;
    localparam int WB_MUX_WTH   = 2;
    localparam int FORW_MUX_WTH = 2;

    localparam logic [ALU_OP_WTH-1:0] ALU_ADD  = 5'b00000;
    localparam logic [ALU_OP_WTH-1:0] ALU_SUB  = 5'b00001;
    localparam logic [ALU_OP_WTH-1:0] ALU_AND  = 5'b00010;
    localparam logic [ALU_OP_WTH-1:0] ALU_OR   = 5'b00011;
    localparam logic [ALU_OP_WTH-1:0] ALU_XOR  = 5'b00100;

    localparam logic [FORW_MUX_WTH-1:0] FWD_REG   = 2'b00;
    localparam logic [FORW_MUX_WTH-1:0] FWD_EXMEM = 2'b01;
    localparam logic [FORW_MUX_WTH-1:0] FWD_MEMWB = 2'b10;

    localparam logic [WB_MUX_WTH-1:0] WB_ALU = 2'b00;
    localparam logic [WB_MUX_WTH-1:0] WB_MEM = 2'b01;
    localparam logic [WB_MUX_WTH-1:0] WB_PC4 = 2'b10;

    // x0 is hardwired to zero, so a producer targeting it never forwards
    function automatic logic fwd_hit(input logic we, input logic [REG_INX_WTH-1:0] rd,
                                     input logic [REG_INX_WTH-1:0] idx);
        return we && (rd == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/rv32i_idex_stage_fwd.sv
// rv32i_fwd_mux: picks the forwarding source for one operand; EX/MEM beats MEM/WB.
import rv32i_idex_pkg::*;

module rv32i_fwd_mux #(
    parameter int W = WORD_WTH,
    parameter int R = REG_INX_WTH
) (
    input  logic [R-1:0]            i_idx,
    input  logic [R-1:0]            i_exmem_rd,
    input  logic                    i_exmem_we,
    input  logic [W-1:0]            i_exmem_res,
    input  logic [R-1:0]            i_memwb_rd,
    input  logic                    i_memwb_we,
    input  logic [W-1:0]            i_memwb_res,
    output logic [FORW_MUX_WTH-1:0] o_sel,
    output logic [W-1:0]            o_data
);

    always_comb begin
        o_sel  = fwd_hit(i_exmem_we, i_exmem_rd, i_idx) ? FWD_EXMEM :
                 fwd_hit(i_memwb_we, i_memwb_rd, i_idx) ? FWD_MEMWB : FWD_REG;
        o_data = (o_sel == FWD_EXMEM) ? i_exmem_res : i_memwb_res;
    end

endmodule

// File: rtl/rv32i_idex_stage.sv
// rv32i_idex_stage: ID/EX pipeline register with RAW forwarding, operand select
// and load-use stall detection feeding the execute ALU.
import rv32i_idex_pkg::*;

module rv32i_idex_stage #(
    parameter int WORD_WTH_P    = WORD_WTH,
    parameter int ADDR_WTH_P    = ADDR_WTH,
    parameter int REG_INX_WTH_P = REG_INX_WTH,
    parameter int ALU_OP_WTH_P  = ALU_OP_WTH,
    parameter int WB_MUX_WTH_P  = WB_MUX_WTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     id_valid_i,
    input  logic [ADDR_WTH_P-1:0]    id_pc_i,
    input  logic [WORD_WTH_P-1:0]    id_rs1_data_i,
    input  logic [WORD_WTH_P-1:0]    id_rs2_data_i,
    input  logic [WORD_WTH_P-1:0]    id_imm_i,
    input  logic [REG_INX_WTH_P-1:0] id_rs1_idx_i,
    input  logic [REG_INX_WTH_P-1:0] id_rs2_idx_i,
    input  logic [REG_INX_WTH_P-1:0] id_rd_idx_i,
    input  logic                     id_rd_we_i,
    input  logic                     id_is_load_i,
    input  logic                     id_op1_pc_i,
    input  logic                     id_op2_imm_i,
    input  logic [ALU_OP_WTH_P-1:0]  id_alu_op_i,
    input  logic [WB_MUX_WTH_P-1:0]  id_wb_sel_i,
    input  logic                     flush_i,
    input  logic [REG_INX_WTH_P-1:0] exmem_rd_idx_i,
    input  logic                     exmem_rd_we_i,
    input  logic [WORD_WTH_P-1:0]    exmem_res_i,
    input  logic [REG_INX_WTH_P-1:0] memwb_rd_idx_i,
    input  logic                     memwb_rd_we_i,
    input  logic [WORD_WTH_P-1:0]    memwb_res_i,
    output logic                     id_stall_o,
    output logic                     ex_valid_o,
    output logic [WORD_WTH_P-1:0]    alu_data1_o,
    output logic [WORD_WTH_P-1:0]    alu_data2_o,
    output logic [ALU_OP_WTH_P-1:0]  alu_opcode_o,
    output logic [WORD_WTH_P-1:0]    ex_store_data_o,
    output logic [ADDR_WTH_P-1:0]    ex_pc_o,
    output logic [WORD_WTH_P-1:0]    ex_imm_o,
    output logic [REG_INX_WTH_P-1:0] ex_rd_idx_o,
    output logic                     ex_rd_we_o,
    output logic                     ex_is_load_o,
    output logic [WB_MUX_WTH_P-1:0]  ex_wb_sel_o
);

    logic                     r_valid;
    logic [ADDR_WTH_P-1:0]    r_pc;
    logic [WORD_WTH_P-1:0]    r_rs1_data;
    logic [WORD_WTH_P-1:0]    r_rs2_data;
    logic [WORD_WTH_P-1:0]    r_imm;
    logic [REG_INX_WTH_P-1:0] r_rs1_idx;
    logic [REG_INX_WTH_P-1:0] r_rs2_idx;
    logic [REG_INX_WTH_P-1:0] r_rd_idx;
    logic                     r_rd_we;
    logic                     r_is_load;
    logic                     r_op1_pc;
    logic                     r_op2_imm;
    logic [ALU_OP_WTH_P-1:0]  r_alu_op;
    logic [WB_MUX_WTH_P-1:0]  r_wb_sel;

    logic                     w_load_use;
    logic [FORW_MUX_WTH-1:0]  w_sel1;
    logic [FORW_MUX_WTH-1:0]  w_sel2;
    logic [WORD_WTH_P-1:0]    w_byp1;
    logic [WORD_WTH_P-1:0]    w_byp2;
    logic [WORD_WTH_P-1:0]    w_rs1_fwd;
    logic [WORD_WTH_P-1:0]    w_rs2_fwd;

    assign w_load_use = r_is_load && r_valid && r_rd_we && (r_rd_idx != '0) && id_valid_i &&
                        ((r_rd_idx == id_rs1_idx_i) || (r_rd_idx == id_rs2_idx_i));
    assign id_stall_o = w_load_use && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_idx  <= '0;
            r_rs2_idx  <= '0;
            r_rd_idx   <= '0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
            r_op1_pc   <= 1'b0;
            r_op2_imm  <= 1'b0;
            r_alu_op   <= ALU_ADD;
            r_wb_sel   <= '0;
        end else if (flush_i || w_load_use) begin
            // bubble: only the qualifying controls matter, datapath keeps stale values
            r_valid    <= 1'b0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
        end else begin
            r_valid    <= id_valid_i;
            r_pc       <= id_pc_i;
            r_rs1_data <= id_rs1_data_i;
            r_rs2_data <= id_rs2_data_i;
            r_imm      <= id_imm_i;
            r_rs1_idx  <= id_rs1_idx_i;
            r_rs2_idx  <= id_rs2_idx_i;
            r_rd_idx   <= id_rd_idx_i;
            r_rd_we    <= id_rd_we_i && id_valid_i;
            r_is_load  <= id_is_load_i;
            r_op1_pc   <= id_op1_pc_i;
            r_op2_imm  <= id_op2_imm_i;
            r_alu_op   <= id_alu_op_i;
            r_wb_sel   <= id_wb_sel_i;
        end
    end

    rv32i_fwd_mux #(.W(WORD_WTH_P), .R(REG_INX_WTH_P)) u_fwd1 (
        .i_idx       (r_rs1_idx),
        .i_exmem_rd  (exmem_rd_idx_i),
        .i_exmem_we  (exmem_rd_we_i),
        .i_exmem_res (exmem_res_i),
        .i_memwb_rd  (memwb_rd_idx_i),
        .i_memwb_we  (memwb_rd_we_i),
        .i_memwb_res (memwb_res_i),
        .o_sel       (w_sel1),
        .o_data      (w_byp1)
    );

    rv32i_fwd_mux #(.W(WORD_WTH_P), .R(REG_INX_WTH_P)) u_fwd2 (
        .i_idx       (r_rs2_idx),
        .i_exmem_rd  (exmem_rd_idx_i),
        .i_exmem_we  (exmem_rd_we_i),
        .i_exmem_res (exmem_res_i),
        .i_memwb_rd  (memwb_rd_idx_i),
        .i_memwb_we  (memwb_rd_we_i),
        .i_memwb_res (memwb_res_i),
        .o_sel       (w_sel2),
        .o_data      (w_byp2)
    );

    always_comb begin
        w_rs1_fwd       = (w_sel1 == FWD_REG) ? r_rs1_data : w_byp1;
        w_rs2_fwd       = (w_sel2 == FWD_REG) ? r_rs2_data : w_byp2;
        alu_data1_o     = r_op1_pc ? WORD_WTH_P'(r_pc) : w_rs1_fwd;
        alu_data2_o     = r_op2_imm ? r_imm : w_rs2_fwd;
        ex_store_data_o = w_rs2_fwd;
    end

    assign ex_valid_o   = r_valid;
    assign alu_opcode_o = r_alu_op;
    assign ex_pc_o      = r_pc;
    assign ex_imm_o     = r_imm;
    assign ex_rd_idx_o  = r_rd_idx;
    assign ex_rd_we_o   = r_rd_we;
    assign ex_is_load_o = r_is_load;
    assign ex_wb_sel_o  = r_wb_sel;

endmodule

// File: tb/tb_rv32i_idex_stage.sv
// tb_rv32i_idex_stage: directed + randomized checks of rv32i_idex_stage against a behavioural model.
module tb_rv32i_idex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i;
    logic        id_rd_we_i, id_is_load_i, id_op1_pc_i, id_op2_imm_i;
    logic [4:0]  id_alu_op_i;
    logic [1:0]  id_wb_sel_i;
    logic        flush_i;
    logic [4:0]  exmem_rd_idx_i, memwb_rd_idx_i;
    logic        exmem_rd_we_i, memwb_rd_we_i;
    logic [31:0] exmem_res_i, memwb_res_i;
    logic        id_stall_o, ex_valid_o, ex_rd_we_o, ex_is_load_o;
    logic [31:0] alu_data1_o, alu_data2_o, ex_store_data_o, ex_pc_o, ex_imm_o;
    logic [4:0]  alu_opcode_o, ex_rd_idx_o;
    logic [1:0]  ex_wb_sel_o;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        valid, we, ld, op1pc, op2imm;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd, op;
        logic [1:0]  wb;
    } ex_t;

    ex_t m, nx;

    rv32i_idex_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i), .id_rd_idx_i(id_rd_idx_i),
        .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i), .id_op1_pc_i(id_op1_pc_i),
        .id_op2_imm_i(id_op2_imm_i), .id_alu_op_i(id_alu_op_i), .id_wb_sel_i(id_wb_sel_i),
        .flush_i(flush_i), .exmem_rd_idx_i(exmem_rd_idx_i), .exmem_rd_we_i(exmem_rd_we_i),
        .exmem_res_i(exmem_res_i), .memwb_rd_idx_i(memwb_rd_idx_i), .memwb_rd_we_i(memwb_rd_we_i),
        .memwb_res_i(memwb_res_i), .id_stall_o(id_stall_o), .ex_valid_o(ex_valid_o),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_opcode_o(alu_opcode_o),
        .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
        .ex_rd_idx_o(ex_rd_idx_o), .ex_rd_we_o(ex_rd_we_o), .ex_is_load_o(ex_is_load_o),
        .ex_wb_sel_o(ex_wb_sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regd);
        if (idx == 0) return regd;
        if (exmem_rd_we_i && exmem_rd_idx_i == idx) return exmem_res_i;
        if (memwb_rd_we_i && memwb_rd_idx_i == idx) return memwb_res_i;
        return regd;
    endfunction

    function automatic logic load_use();
        return m.valid && m.ld && m.we && m.rd != 0 && id_valid_i &&
               (m.rd == id_rs1_idx_i || m.rd == id_rs2_idx_i);
    endfunction

    task automatic clear_in();
        id_valid_i = 0; id_pc_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0;
        id_rs1_idx_i = 0; id_rs2_idx_i = 0; id_rd_idx_i = 0; id_rd_we_i = 0; id_is_load_i = 0;
        id_op1_pc_i = 0; id_op2_imm_i = 0; id_alu_op_i = 0; id_wb_sel_i = 0; flush_i = 0;
        exmem_rd_idx_i = 0; exmem_rd_we_i = 0; exmem_res_i = 0;
        memwb_rd_idx_i = 0; memwb_rd_we_i = 0; memwb_res_i = 0;
    endtask

    task automatic rand_in();
        id_valid_i = ($urandom_range(0, 7) != 0);
        id_pc_i = $urandom; id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
        id_rs1_idx_i = 5'($urandom_range(0, 7)); id_rs2_idx_i = 5'($urandom_range(0, 7));
        id_rd_idx_i = 5'($urandom_range(0, 7));
        id_rd_we_i = $urandom_range(0, 1); id_is_load_i = ($urandom_range(0, 2) == 0);
        id_op1_pc_i = ($urandom_range(0, 3) == 0); id_op2_imm_i = ($urandom_range(0, 2) == 0);
        id_alu_op_i = 5'($urandom); id_wb_sel_i = 2'($urandom_range(0, 2));
        flush_i = ($urandom_range(0, 7) == 0);
        exmem_rd_idx_i = 5'($urandom_range(0, 7)); exmem_rd_we_i = $urandom_range(0, 1);
        exmem_res_i = $urandom;
        memwb_rd_idx_i = 5'($urandom_range(0, 7)); memwb_rd_we_i = $urandom_range(0, 1);
        memwb_res_i = $urandom;
    endtask

    // compare every output with the model for the current EX contents and inputs
    task automatic settle();
        #1;
        chk("stall", 32'(id_stall_o), 32'(load_use() && !flush_i));
        chk("ex_valid", 32'(ex_valid_o), 32'(m.valid));
        chk("ex_rd_we", 32'(ex_rd_we_o), 32'(m.we));
        chk("ex_is_load", 32'(ex_is_load_o), 32'(m.ld));
        if (m.valid) begin
            chk("alu_data1", alu_data1_o, m.op1pc ? m.pc : fwd(m.rs1, m.rs1d));
            chk("alu_data2", alu_data2_o, m.op2imm ? m.imm : fwd(m.rs2, m.rs2d));
            chk("store_data", ex_store_data_o, fwd(m.rs2, m.rs2d));
            chk("alu_opcode", 32'(alu_opcode_o), 32'(m.op));
            chk("ex_pc", ex_pc_o, m.pc);
            chk("ex_imm", ex_imm_o, m.imm);
            chk("ex_rd_idx", 32'(ex_rd_idx_o), 32'(m.rd));
            chk("ex_wb_sel", 32'(ex_wb_sel_o), 32'(m.wb));
        end
    endtask

    task automatic tick();
        nx = m;
        if (flush_i || load_use()) begin
            nx.valid = 0; nx.we = 0; nx.ld = 0;
        end else begin
            nx.valid = id_valid_i; nx.pc = id_pc_i; nx.rs1d = id_rs1_data_i; nx.rs2d = id_rs2_data_i;
            nx.imm = id_imm_i; nx.rs1 = id_rs1_idx_i; nx.rs2 = id_rs2_idx_i; nx.rd = id_rd_idx_i;
            nx.we = id_rd_we_i && id_valid_i; nx.ld = id_is_load_i; nx.op1pc = id_op1_pc_i;
            nx.op2imm = id_op2_imm_i; nx.op = id_alu_op_i; nx.wb = id_wb_sel_i;
        end
        @(posedge clk_i);
        m = nx;
        @(negedge clk_i);
    endtask

    task automatic reset_model();
        m = '{default: '0};
    endtask

    initial begin
        clear_in();
        reset_model();
        rst_n_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_ex_valid", 32'(ex_valid_o), 0);
        chk("rst_ex_rd_we", 32'(ex_rd_we_o), 0);
        chk("rst_alu_opcode", 32'(alu_opcode_o), 0);
        chk("rst_stall", 32'(id_stall_o), 0);
        chk("rst_alu_data1", alu_data1_o, 0);
        @(negedge clk_i);
        rst_n_i = 1;

        // EX/MEM forwarding
        id_valid_i = 1; id_rs1_idx_i = 5; id_rs1_data_i = 32'hDEAD; id_alu_op_i = 0;
        settle(); tick();
        clear_in(); exmem_rd_idx_i = 5; exmem_rd_we_i = 1; exmem_res_i = 32'h1234;
        settle(); chk("exmem_fwd", alu_data1_o, 32'h1234); tick();

        // EX/MEM beats MEM/WB; x0 never forwarded
        clear_in(); id_valid_i = 1; id_rs1_idx_i = 7; id_rs1_data_i = 32'h11;
        settle(); tick();
        clear_in(); exmem_rd_idx_i = 7; exmem_rd_we_i = 1; exmem_res_i = 32'hAA;
        memwb_rd_idx_i = 7; memwb_rd_we_i = 1; memwb_res_i = 32'hBB;
        settle(); chk("fwd_priority", alu_data1_o, 32'hAA); tick();
        clear_in(); id_valid_i = 1; id_rs1_idx_i = 0; id_rs1_data_i = 32'h55;
        settle(); tick();
        clear_in(); exmem_rd_idx_i = 0; exmem_rd_we_i = 1; exmem_res_i = 32'hAA;
        memwb_rd_idx_i = 0; memwb_rd_we_i = 1; memwb_res_i = 32'hBB;
        settle(); chk("fwd_x0", alu_data1_o, 32'h55); tick();

        // load-use: lw x3, then add x?, x3 -> stall, bubble, MEM/WB forward
        clear_in(); id_valid_i = 1; id_is_load_i = 1; id_rd_we_i = 1; id_rd_idx_i = 3;
        id_wb_sel_i = 2'b01;
        settle(); tick();
        clear_in(); id_valid_i = 1; id_rs1_idx_i = 3; id_rs1_data_i = 32'h999;
        settle(); chk("lu_stall", 32'(id_stall_o), 1); tick();
        chk("lu_bubble", 32'(ex_valid_o), 0);
        exmem_rd_idx_i = 3; exmem_rd_we_i = 0;
        settle(); chk("lu_stall_drop", 32'(id_stall_o), 0); tick();
        clear_in(); memwb_rd_idx_i = 3; memwb_rd_we_i = 1; memwb_res_i = 32'h77;
        settle(); chk("lu_memwb_fwd", alu_data1_o, 32'h77); tick();

        // flush wins over load-use
        clear_in(); id_valid_i = 1; id_is_load_i = 1; id_rd_we_i = 1; id_rd_idx_i = 4;
        settle(); tick();
        clear_in(); id_valid_i = 1; id_rs2_idx_i = 4; flush_i = 1;
        settle(); chk("flush_stall", 32'(id_stall_o), 0); tick();
        flush_i = 0; id_valid_i = 0;
        settle(); chk("flush_valid", 32'(ex_valid_o), 0); tick();

        // operand select
        clear_in(); id_valid_i = 1; id_op1_pc_i = 1; id_pc_i = 32'h100; id_op2_imm_i = 1;
        id_imm_i = 32'hFFFFFFFC; id_rs2_idx_i = 6; id_rs2_data_i = 32'h99;
        settle(); tick();
        clear_in(); memwb_rd_idx_i = 6; memwb_rd_we_i = 1; memwb_res_i = 32'h4242;
        settle();
        chk("sel_data1", alu_data1_o, 32'h100);
        chk("sel_data2", alu_data2_o, 32'hFFFFFFFC);
        chk("sel_store", ex_store_data_o, 32'h4242);
        tick();

        for (int i = 0; i < 400; i++) begin
            rand_in(); settle(); tick();
        end

        // asynchronous reset mid-stream, checked before the next rising edge
        clear_in(); id_valid_i = 1; id_rd_we_i = 1; id_rd_idx_i = 9; id_alu_op_i = 5'h1F;
        settle(); tick();
        #3 rst_n_i = 0;
        #1;
        chk("mid_rst_valid", 32'(ex_valid_o), 0);
        chk("mid_rst_rd_we", 32'(ex_rd_we_o), 0);
        chk("mid_rst_opcode", 32'(alu_opcode_o), 0);
        reset_model();
        @(negedge clk_i);
        rst_n_i = 1;
        for (int i = 0; i < 100; i++) begin
            rand_in(); settle(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
